// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions: FSM states, round count, Rcon and RotWord.
package aes_pkg;

  typedef enum logic [1:0] {IDLE, EXPAND, READY, STEP} aes_dks_state_e;

  localparam logic [3:0] AES_NR = 4'd10;

  // Rcon(i) for i = 1..10; anything else yields zero.
  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// 32-bit SubWord from forward bSbox instances. With AES_DKS_SERIAL_SBOX_EN one
// S-box is shared over the 4 bytes; the word is complete in the cycle sel==3.
import aes_pkg::*;

module aes_sub_word (
`ifdef AES_DKS_SERIAL_SBOX_EN
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [1:0]  sel,
`endif
  input  logic [31:0] w_in,
  output logic [31:0] w_out
);

`ifdef AES_DKS_SERIAL_SBOX_EN
  logic [3:0][7:0] wv;
  logic [3:0][7:0] res;
  logic [3:0][7:0] ov;
  logic [7:0]      b_in;
  logic [7:0]      b_out;

  assign wv   = w_in;
  // sel 0 addresses byte 0 (the MSB byte), i.e. packed position 3.
  assign b_in = wv[~sel];

  bSbox u_sbox (.A(b_in), .encrypt(1'b1), .Q(b_out));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  res      <= '0;
    else if (en) res[~sel] <= b_out;
  end

  // Current byte bypasses the register so the full word is ready on the 4th cycle.
  always_comb begin
    ov       = res;
    ov[~sel] = b_out;
    w_out    = ov;
  end
`else
  for (genvar i = 0; i < 4; i++) begin : g_sbox
    bSbox u_sbox (.A(w_in[8*i +: 8]), .encrypt(1'b1), .Q(w_out[8*i +: 8]));
  end
`endif

endmodule

// File: rtl/bSbox.sv
// AES byte S-box: encrypt=1 gives the forward S-box, encrypt=0 the inverse.
// Built from the GF(2^8) inverse (x^254) and the AES affine maps.
module bSbox (
  input  logic [7:0] A,
  input  logic       encrypt,
  output logic [7:0] Q
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = gf_mul(x, x);
    acc = sq;
    for (int i = 0; i < 6; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  logic [7:0] t;

  always_comb begin
    t = 8'h00;
    if (encrypt) begin
      t = gf_inv(A);
      Q = t ^ rotl(t, 1) ^ rotl(t, 2) ^ rotl(t, 3) ^ rotl(t, 4) ^ 8'h63;
    end else begin
      t = rotl(A, 1) ^ rotl(A, 3) ^ rotl(A, 6) ^ 8'h05;
      Q = gf_inv(t);
    end
  end

endmodule

// File: rtl/aes_dec_key_sched.sv
// AES-128 decryption key scheduler: expands to round 10, then walks back to round 0.
// Build option AES_DKS_SERIAL_SBOX_EN: single shared S-box, 4 cycles per step.
import aes_pkg::*;

module aes_dec_key_sched (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_round,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         busy
);

  aes_dks_state_e state;
  logic [127:0]   wk;
  logic [127:0]   last_rk;
  logic [3:0]     cnt;

  logic [31:0]    w0, w1, w2, w3;
  logic [31:0]    n0, n1, n2, n3;
  logic [31:0]    sw_in, sw_out, t_fwd;
  logic [127:0]   fwd_rk, inv_rk;
  logic           step_done;
  logic           key_hs, rk_hs;

  assign key_hs   = key_valid && key_ready;
  assign rk_hs    = rk_valid && rk_ready;
  assign rk_out   = wk;
  assign rk_round = cnt;

  assign {w0, w1, w2, w3} = wk;

  // Inverse step recovers the previous round's last three words by XOR alone.
  assign n3 = w3 ^ w2;
  assign n2 = w2 ^ w1;
  assign n1 = w1 ^ w0;

  assign sw_in  = (state == STEP) ? rot_word(n3) : rot_word(w3);
  assign t_fwd  = w0 ^ sw_out ^ {rcon(cnt + 4'd1), 24'h0};
  assign fwd_rk = {t_fwd, t_fwd ^ w1, t_fwd ^ w1 ^ w2, t_fwd ^ w1 ^ w2 ^ w3};
  assign n0     = w0 ^ sw_out ^ {rcon(cnt), 24'h0};
  assign inv_rk = {n0, n1, n2, n3};

`ifdef AES_DKS_SERIAL_SBOX_EN
  logic [1:0] bc;
  logic       stepping;

  assign stepping  = (state == EXPAND && cnt != AES_NR) || state == STEP;
  assign step_done = (bc == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        bc <= 2'd0;
    else if (stepping) bc <= bc + 2'd1;
    else               bc <= 2'd0;
  end

  aes_sub_word u_sub_word (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (stepping),
    .sel   (bc),
    .w_in  (sw_in),
    .w_out (sw_out)
  );
`else
  assign step_done = 1'b1;

  aes_sub_word u_sub_word (
    .w_in  (sw_in),
    .w_out (sw_out)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wk        <= '0;
      last_rk   <= '0;
      cnt       <= '0;
      key_ready <= 1'b0;
      rk_valid  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          key_ready <= 1'b1;
          if (key_hs) begin
            wk        <= key_in;
            cnt       <= '0;
            state     <= EXPAND;
            key_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        EXPAND: begin
          if (cnt == AES_NR) begin
            last_rk   <= wk;
            state     <= READY;
            rk_valid  <= 1'b1;
            key_ready <= 1'b1;
            busy      <= 1'b0;
          end else if (step_done) begin
            wk  <= fwd_rk;
            cnt <= cnt + 4'd1;
          end
        end
        READY: begin
          // A new key overrides any pending round-key handshake.
          if (key_hs) begin
            wk        <= key_in;
            cnt       <= '0;
            state     <= EXPAND;
            rk_valid  <= 1'b0;
            key_ready <= 1'b0;
            busy      <= 1'b1;
          end else if (rk_hs) begin
            if (cnt != 4'd0) begin
              state     <= STEP;
              rk_valid  <= 1'b0;
              key_ready <= 1'b0;
              busy      <= 1'b1;
            end else begin
              wk  <= last_rk;
              cnt <= AES_NR;
            end
          end
        end
        STEP: begin
          if (step_done) begin
            wk        <= inv_rk;
            cnt       <= cnt - 4'd1;
            state     <= READY;
            rk_valid  <= 1'b1;
            key_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_dec_key_sched.sv
// Randomized self-checking bench for aes_dec_key_sched against a FIPS-197 key expansion model.
module tb_aes_dec_key_sched;

`ifdef AES_DKS_SERIAL_SBOX_EN
  localparam int LAT = 41;
  localparam int BUB = 4;
`else
  localparam int LAT = 11;
  localparam int BUB = 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;
  logic         rk_valid;
  logic         rk_ready;
  logic         busy;

  int errors = 0;
  int checks = 0;

  logic [7:0]   sbox_t [0:255];
  logic [127:0] exp_rk [0:10];
  logic [127:0] got_rk [0:10];

  always #5 clk = ~clk;

  aes_dec_key_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_in    (key_in),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .rk_out    (rk_out),
    .rk_round  (rk_round),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box table: inverse found by exhaustive search, then the FIPS bitwise affine rule.
  task automatic build_sbox();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox_t[x] = s;
    end
  endtask

  // Standard forward key expansion into 44 words; round r = words 4r..4r+3.
  task automatic expand(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]], sbox_t[t[31:24]]} ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    @(negedge clk);
    while (!rk_valid && n < 500) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic load(input logic [127:0] k);
    int n;
    expand(k);
    key_in    = k;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    n = 0;
    while (!rk_valid && n < 500) begin
      n++;
      @(negedge clk);
    end
    chk("latency", 128'(n), 128'(LAT));
    chk("busy_at_ready", 128'(busy), 128'(0));
  endtask

  // Entered at a negedge where round 'from' is valid; leaves rk_ready=1 on round 'to'.
  task automatic consume(input int from, input int to, input bit rnd);
    int n;
    logic [127:0] hold;
    for (int r = from; r >= to; r--) begin
      if (r != from) begin
        wait_valid(n);
        chk("bubble", 128'(n), 128'(BUB));
      end
      chk("round", 128'(rk_round), 128'(r));
      chk("rk", rk_out, exp_rk[r]);
      got_rk[r] = rk_out;
      if (rnd) begin
        while ($urandom_range(0, 2) == 0) begin
          rk_ready = 1'b0;
          hold = rk_out;
          @(negedge clk);
          chk("stall_rk", rk_out, hold);
          chk("stall_round", 128'(rk_round), 128'(r));
        end
      end
      rk_ready = 1'b1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [127:0] hold, k;
    build_sbox();
    rst_n = 1'b0; key_valid = 1'b0; key_in = '0; rk_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_key_ready", 128'(key_ready), 128'(0));
    chk("rst_rk_valid", 128'(rk_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_rk_out", rk_out, 128'h0);
    chk("rst_rk_round", 128'(rk_round), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("key_ready_after_rst", 128'(key_ready), 128'(1));
    rk_ready = 1'b1;

    // FIPS-197 key with backpressure at round 7
    load(128'h2b7e151628aed2a6abf7158809cf4f3c);
    chk("fips_r10", rk_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    consume(10, 8, 1'b0);
    wait_valid(n);
    chk("bubble_r7", 128'(n), 128'(BUB));
    chk("round_r7", 128'(rk_round), 128'(7));
    rk_ready = 1'b0;
    hold = rk_out;
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", 128'(rk_valid), 128'(1));
      chk("bp_round", 128'(rk_round), 128'(7));
      chk("bp_rk", rk_out, hold);
    end
    consume(7, 0, 1'b0);
    chk("fips_r9", got_rk[9], 128'hac7766f319fadc2128d12941575c006e);
    chk("fips_r1", got_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("fips_r0", got_rk[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);

    // Wrap from round 0 back to round 10 with no re-expansion
    wait_valid(n);
    chk("wrap_bubble", 128'(n), 128'(0));
    chk("wrap_round", 128'(rk_round), 128'(10));
    chk("wrap_rk", rk_out, exp_rk[10]);
    chk("wrap_busy", 128'(busy), 128'(0));

    // Reload all-zero key at round 5, with rk handshake in the same cycle
    consume(10, 6, 1'b0);
    wait_valid(n);
    chk("bubble_r5", 128'(n), 128'(BUB));
    chk("round_r5", 128'(rk_round), 128'(5));
    load(128'h0);
    chk("zero_r10", rk_out, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    consume(10, 0, 1'b0);

    // Reset while expanding
    key_in = {$urandom, $urandom, $urandom, $urandom};
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy_expand", 128'(busy), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("midrst_rk_valid", 128'(rk_valid), 128'(0));
    chk("midrst_busy", 128'(busy), 128'(0));
    chk("midrst_key_ready", 128'(key_ready), 128'(0));
    chk("midrst_round", 128'(rk_round), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Random keys with random backpressure
    repeat (5) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      load(k);
      consume(10, 0, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_dec_key_sched.md
# aes_dec_key_sched

Decryption-side AES-128 key scheduler. It accepts a cipher key and expands it forward to round key 10, then delivers round keys in reverse order (10 down to 0) to the inverse-cipher datapath, one per handshake. Each earlier round key is derived by inverting one key-expansion step. SubWord uses the codebase's `bSbox` with `encrypt=1`, because the key schedule always uses the forward S-box. The block sits between key-load logic and the inverse round engine.

## Interface
- No parameters; AES-128 only (Nk=4, Nr=10).
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `key_in`  in  128  cipher key; bit 127 is byte 0, MSB.
- `key_valid`  in  1  key offered.
- `key_ready`  out  1  key accepted on `key_valid && key_ready`.
- `rk_out`  out  128  current round key; same byte order as `key_in`.
- `rk_round`  out  4  index of `rk_out`, counting 10 down to 0.
- `rk_valid`  out  1  `rk_out`/`rk_round` are valid.
- `rk_ready`  in  1  consumer takes the key on `rk_valid && rk_ready`.
- `busy`  out  1  high in EXPAND or STEP.

## Operation
- Forward step, Rcon(i) for i=1..10 = 01,02,04,08,10,20,40,80,1b,36:
  - w4 = w0 ^ SubWord(RotWord(w3)) ^ {Rcon(i),24'h0}
  - w5 = w4^w1, w6 = w5^w2, w7 = w6^w3
- Inverse step, producing round i-1 from round i:
  - w3 = w7^w6, w2 = w6^w5, w1 = w5^w4
  - w0 = w4 ^ SubWord(RotWord(w3)) ^ {Rcon(i),24'h0}
- States:
  - IDLE: `key_ready`=1. On key handshake: working reg ← `key_in`, round counter ← 0, go to EXPAND.
  - EXPAND: apply forward steps until the counter reaches 10, then copy working reg into `last_rk`, go to READY.
  - READY: `rk_valid`=1, `rk_out`=working reg, `key_ready`=1.
    - On rk handshake with `rk_round`>0: go to STEP.
    - On rk handshake with `rk_round`=0: working reg ← `last_rk`, counter ← 10, stay in READY (next block reuses the schedule without re-expanding).
  - STEP: apply one inverse step, decrement counter, return to READY.
- Key handshake in READY aborts delivery: go to EXPAND with the new key. If key and rk handshakes fire in the same cycle, the key handshake wins and the rk handshake is still counted as consumed.
- `key_ready`=0 in EXPAND and STEP; `key_valid` is ignored there.
- Reset at any point: IDLE, all registers cleared.

## Timing
- Reset values: `key_ready`=0 while `rst_n` is low, 1 from the first clock after release. `rk_valid`=0, `busy`=0, `rk_out`=0, `rk_round`=0.
- Unrolled build:
  - 1 forward step per cycle. Key handshake to first `rk_valid` = 11 cycles.
  - STEP = 1 cycle, so `rk_valid` drops for exactly 1 cycle between keys. Wrap from round 0 back to round 10 costs 0 bubble cycles.
- Serial build: every step takes 4 cycles. Key handshake to first `rk_valid` = 41 cycles; STEP = 4 bubble cycles.
- `rk_out` and `rk_round` are registered and stable while `rk_valid` is high and `rk_ready` is low.

## Configuration
- `AES_DKS_SERIAL_SBOX_EN` defined: one `bSbox` instance, time-multiplexed over the 4 SubWord bytes by a 2-bit byte counter. Each step takes 4 cycles; the result is committed on the 4th.
- Undefined (default): four parallel `bSbox` instances; each step takes 1 cycle.
- Output key sequence is identical in both builds; only cycle counts differ.

## Structure
- `aes_pkg` holds:
  - state enum (IDLE, EXPAND, READY, STEP)
  - `AES_NR` = 10
  - Rcon lookup function
  - `RotWord` function
- Sub-module `aes_sub_word`: 32-bit SubWord built from `bSbox` (`encrypt` tied to 1). In the serial build it wraps a single instance plus the byte mux and the 4-entry result register.

## Test plan
- FIPS-197 key `2b7e151628aed2a6abf7158809cf4f3c`, `rk_ready` held high:
  - first output is round 10 = `d014f9a8c9ee2589e13f0cc8b6630ca6`
  - next is round 9 = `ac7766f319fadc2128d12941575c006e`
  - round 1 = `a0fafe1788542cb123a339392a6c7605`
  - round 0 = the key itself
- Continue after round 0: round 10 key is re-presented with no EXPAND; `busy` stays 0.
- Backpressure: hold `rk_ready`=0 for 5 cycles at round 7. `rk_out` and `rk_round`=7 stay stable; no skipped or duplicated round.
- Reload mid-stream: at round 5, load key all-zero. Next output is round 10 = `b4ef5bcb3e92e21123e951cf6f8f188e`.
- Assert `rst_n`=0 during EXPAND: `rk_valid`=0 immediately. After release, a fresh key yields the correct round 10 key.
- Run all of the above with `AES_DKS_SERIAL_SBOX_EN` defined: same keys; 41-cycle first latency and 4-cycle bubbles.
